// File: rtl/beep_play_ctrl.sv
// -----------------------------------------------------------------------------
// beep_play_ctrl
//
// Playback sequencer in front of the menu melody player. A one-cycle play
// request turns into a `flag` level that lasts exactly one full melody
// (NOTE_CNT notes of NOTE_CYC cycles each). The player's note counters
// therefore wrap back to note 0 at the end. After a melody, a cooldown of
// GAP_CYC cycles follows. One request that arrives during play or cooldown is
// remembered and replayed when the cooldown ends.
//
// Parameters:
//   NOTE_CYC  cycles per note (must match the player's per-note length)
//   NOTE_CNT  notes per melody (must match the player's wrap count)
//   GAP_CYC   cooldown cycles after a melody (minimum 1)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   req        play request pulse, sampled every cycle
//   stop       abort pulse; wins over req in the same cycle
//   mute       level; gates flag only, all timing keeps running
//   flag       registered enable to the melody player
//   busy       high while in PLAY or COOL
//   done       one-cycle pulse after a naturally completed melody
//   note_idx   current note index in PLAY, zero otherwise
//   state_dbg  current FSM state (IDLE=0, PLAY=1, COOL=2)
//
// Handshake: req and stop are plain one-cycle pulses with no ready/ack. A req
// is accepted in IDLE. In PLAY/COOL it fills the single pending slot; any
// further req is dropped while that slot is full.
// -----------------------------------------------------------------------------
module beep_play_ctrl #(
  parameter int NOTE_CYC = 15_000_000,
  parameter int NOTE_CNT = 57,
  parameter int GAP_CYC  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       stop,
  input  logic       mute,
  output logic       flag,
  output logic       busy,
  output logic       done,
  output logic [7:0] note_idx,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    COOL = 2'd2
  } state_t;

  // Terminal counts, sized to each counter so the compares stay width-clean.
  localparam logic [23:0] CYC_LAST  = 24'(NOTE_CYC - 1);
  localparam logic [7:0]  NOTE_LAST = 8'(NOTE_CNT - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic [23:0] cyc_q,   cyc_d;
  logic [7:0]  note_q,  note_d;
  logic [31:0] gap_q,   gap_d;
  logic        pend_q,  pend_d;
  logic        flag_q;
  logic        done_q;

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    note_d  = note_q;
    gap_d   = gap_q;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = PLAY;
          cyc_d   = '0;
          note_d  = '0;
          gap_d   = '0;
        end
      end

      PLAY: begin
        if (req) pend_d = 1'b1;
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (note_q == NOTE_LAST) begin
            // Last cycle of the last note: the melody is complete.
            state_d = COOL;
            note_d  = '0;
            gap_d   = '0;
          end else begin
            note_d = note_q + 8'd1;
          end
        end else begin
          cyc_d = cyc_q + 24'd1;
        end
      end

      COOL: begin
        if (req) pend_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          // A req that arrives on the final cooldown cycle with nothing
          // pending goes straight back to PLAY. It is not parked in IDLE.
          // The flag therefore has no extra idle cycle, and a replay request
          // is never held in IDLE. A req in the same cycle as an existing
          // pending request is dropped: the slot is consumed by this replay.
          if (pend_q || req) begin
            state_d = PLAY;
            pend_d  = 1'b0;
            cyc_d   = '0;
            note_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        note_d  = '0;
        gap_d   = '0;
        pend_d  = 1'b0;
      end
    endcase

    // Abort overrides everything, including a same-cycle request.
    if (stop) begin
      state_d = IDLE;
      cyc_d   = '0;
      note_d  = '0;
      gap_d   = '0;
      pend_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      note_q  <= '0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      note_q  <= note_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      // Look ahead to the next state so that flag goes high on the same
      // edge where PLAY is entered.
      flag_q  <= (state_d == PLAY) && !mute;
      done_q  <= (state_q == PLAY) && (state_d == COOL);
    end
  end

  assign flag      = flag_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  // note_q is cleared on every state change, so it already reads zero
  // outside PLAY.
  assign note_idx  = note_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_beep_play_ctrl.sv
// -----------------------------------------------------------------------------
// tb_beep_play_ctrl
//
// Directed bench for beep_play_ctrl with NOTE_CYC=4, NOTE_CNT=3, GAP_CYC=5.
// A melody therefore lasts 12 cycles and the cooldown lasts 5 cycles.
// Cycle k counts from the clock edge that samples the request (k=1 is the
// first cycle after that edge). Outputs are sampled 1 time unit after each
// rising edge, and inputs are driven at that same point.
// -----------------------------------------------------------------------------
module tb_beep_play_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       stop;
  logic       mute;
  logic       flag;
  logic       busy;
  logic       done;
  logic [7:0] note_idx;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  beep_play_ctrl #(
    .NOTE_CYC (4),
    .NOTE_CNT (3),
    .GAP_CYC  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .stop      (stop),
    .mute      (mute),
    .flag      (flag),
    .busy      (busy),
    .done      (done),
    .note_idx  (note_idx),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ef, input logic eb,
                            input logic ed, input logic [7:0] en);
    check({tag, ".flag"}, 32'(flag), 32'(ef));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
    check({tag, ".note"}, 32'(note_idx), 32'(en));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request and one full unmuted melody. The expected timeline is:
  // flag high for k=1..12, note 0/1/2 for 4 cycles each, done at k=13,
  // COOL for k=13..17, and IDLE from k=18.
  task automatic run_single(input string tag);
    req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      req = 1'b0;
      check_outs($sformatf("%s[%0d]", tag, k),
                 k <= 12, k <= 17, k == 13,
                 (k <= 12) ? 8'((k - 1) / 4) : 8'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst  = 1'b1;
    req  = 1'b0;
    stop = 1'b0;
    mute = 1'b0;
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    check("reset.state", 32'(state_dbg), 32'd0);

    rst = 1'b0;
    step();
    check_outs("idle", 1'b0, 1'b0, 1'b0, 8'd0);

    // Reset wins over a request sampled on the same edge.
    rst = 1'b1;
    req = 1'b1;
    step();
    rst = 1'b0;
    req = 1'b0;
    check_outs("rst_vs_req", 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    check_outs("rst_vs_req_after", 1'b0, 1'b0, 1'b0, 8'd0);

    // Single melody.
    run_single("single");

    // Pending replay: two extra requests during PLAY give exactly one
    // replay. The first melody runs k=1..12 and the second runs k=18..29,
    // so flag is low for the 5 cycles k=13..17.
    req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      req = (k == 3) || (k == 7);
      check_outs($sformatf("replay[%0d]", k),
                 (k <= 12) || (k >= 18 && k <= 29),
                 k <= 34,
                 (k == 13) || (k == 30),
                 (k <= 12) ? 8'((k - 1) / 4) :
                 (k >= 18 && k <= 29) ? 8'((k - 18) / 4) : 8'd0);
    end

    // Abort on the 6th PLAY cycle, with a request in the same cycle.
    req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      req  = (k == 6);
      stop = (k == 6);
      check_outs($sformatf("abort[%0d]", k),
                 k <= 6, k <= 6, 1'b0,
                 (k <= 6) ? 8'((k - 1) / 4) : 8'd0);
    end
    stop = 1'b0;

    // Mute covering PLAY cycles 3..7. Mute is sampled one edge later, so it
    // is driven high from cycle 2 through cycle 6.
    req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      req  = 1'b0;
      mute = (k >= 2) && (k <= 6);
      check_outs($sformatf("mute[%0d]", k),
                 (k <= 12) && !(k >= 3 && k <= 7),
                 k <= 17, k == 13,
                 (k <= 12) ? 8'((k - 1) / 4) : 8'd0);
    end
    mute = 1'b0;

    // Reset in the middle of COOL while a request is pending.
    req = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      req = (k == 5);
      check_outs($sformatf("rstcool[%0d]", k),
                 k <= 12, 1'b1, k == 13,
                 (k <= 12) ? 8'((k - 1) / 4) : 8'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("rstcool.after", 1'b0, 1'b0, 1'b0, 8'd0);
    check("rstcool.state", 32'(state_dbg), 32'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      check_outs($sformatf("rstcool.noreplay[%0d]", k), 1'b0, 1'b0, 1'b0, 8'd0);
    end
    run_single("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/beep_play_ctrl.md
# beep_play_ctrl

Playback sequencer directly upstream of the menu melody player. It turns one-cycle play requests into an exactly-timed `flag` level that drives the player's enable. The level lasts exactly one full melody (NOTE_CNT notes × NOTE_CYC cycles), so the player's note counters end at note 0. The block also handles a post-melody cooldown, one pending request, abort and mute, and exports note-position and status for LED/menu logic.

## Interface
- `NOTE_CYC`, default 15_000_000: cycles per note; must equal the player's per-note length.
- `NOTE_CNT`, default 57: notes per melody; must equal the player's wrap count.
- `GAP_CYC`, default 25_000_000: cooldown cycles after a melody; minimum 1.
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous and active-high.
- `req` in 1: play request pulse. Sampled every cycle.
- `stop` in 1: abort pulse.
- `mute` in 1: level; silences output without disturbing timing.
- `flag` out 1: enable to the melody player.
- `busy` out 1: high in PLAY or COOL.
- `done` out 1: one-cycle pulse on natural melody completion.
- `note_idx` out 8: current note index, 0..NOTE_CNT-1. Zero outside PLAY.

## Operation
- States:
  - IDLE: `busy`=0.
  - PLAY: counting notes.
  - COOL: counting GAP_CYC.
- Counters:
  - `cyc_cnt`: 24-bit, 0..NOTE_CYC-1 in PLAY.
  - `note_idx`: 8-bit, 0..NOTE_CNT-1.
  - `gap_cnt`: 32-bit, 0..GAP_CYC-1 in COOL.
  - All counters are cleared on every state entry.
- IDLE → PLAY: `req`=1 and `stop`=0.
- In PLAY:
  - `cyc_cnt` increments each cycle.
  - At `cyc_cnt`=NOTE_CYC-1, `cyc_cnt` wraps to 0 and `note_idx` increments.
  - At `note_idx`=NOTE_CNT-1 and `cyc_cnt`=NOTE_CYC-1, go to COOL.
- In COOL:
  - `gap_cnt` increments each cycle.
  - At `gap_cnt`=GAP_CYC-1, go to PLAY if `pending`=1 (clearing `pending`), else go to IDLE.
- `pending` (1 bit):
  - Set by `req` while in PLAY or COOL.
  - Further requests are dropped; there is no queue deeper than 1.
  - Cleared on entering PLAY from COOL, by `stop`, and by `rst`.
- `stop`, in any state:
  - Next state is IDLE, all counters clear, `pending` clears, no `done`.
  - `stop` has priority over `req` in the same cycle.
- `flag` is registered: `flag` = (next state is PLAY) && !`mute`.
- `mute`:
  - Affects only `flag`. State, counters, `busy`, `done` and `note_idx` all run normally.
  - Toggling `mute` mid-melody gates `flag` on and off from the next cycle.
- `done` is registered: high for the single cycle following the PLAY→COOL transition.

## Timing
- Reset values: state IDLE, `flag`=0, `busy`=0, `done`=0, `note_idx`=0, `pending`=0, all counters 0.
- `rst` overrides `req` and `stop` in the same cycle.
- Request latency: `req` sampled at edge t gives `flag`=1 and `busy`=1 from edge t+1.
- Unmuted melody: `flag` is high for exactly NOTE_CNT×NOTE_CYC consecutive cycles.
- Completion:
  - `done` rises at the same edge `flag` falls, for 1 cycle.
  - `busy` stays high through COOL.
  - COOL lasts exactly GAP_CYC cycles.
- Pending replay:
  - `flag` returns high at the edge COOL ends, with no IDLE cycle.
  - The low gap on `flag` is exactly GAP_CYC cycles.
- `req` in the same cycle COOL ends with `pending`=0: it sets `pending`, IDLE is reached, and the request is held. Implementation is free to instead go straight to PLAY; both are accepted, but the choice must be documented in RTL.
- After `stop`: `flag`, `busy` and `note_idx` are 0 at the next edge. The downstream player's position is then mid-melody; this is not corrected here.
- `note_idx` updates on the same edge as the `cyc_cnt` wrap.

## Test plan
- Bench parameters: NOTE_CYC=4, NOTE_CNT=3, GAP_CYC=5.
- Single request: `req` pulse at cycle 10 → `flag` high cycles 11–22 (12 cycles), `note_idx` 0,1,2 for 4 cycles each, `done`=1 at cycle 23 only, `busy` low from cycle 28.
- Pending replay: two extra `req` pulses during PLAY → exactly one replay, `flag` low for exactly 5 cycles between melodies, one `done` per melody.
- Abort: `stop` at the 6th PLAY cycle, with `req` in the same cycle → `flag`, `busy` and `note_idx` are 0 next cycle, no `done`, and no replay.
- Mute: `mute` high for PLAY cycles 3–7 → `flag` low during those cycles, `done` timing unchanged, `note_idx` sequence unchanged.
- Reset mid-COOL with `pending` set → all outputs 0 next cycle, no later replay, and a fresh `req` then yields a full 12-cycle `flag`.
